mem_access_ctrl: RTL

//  MEM-stage load/store sequencer between the EX/MEM pipeline register and Data_Memory.
//  - Accepts one load/store request at a time and validates it.
//  - Drives the Data_Memory Read/Write/Address/Write_data/Func3 strobes and waits out busywait.
//  - Returns load data and the destination register to MEM/WB, and stalls the pipeline while busy.

---
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer between the EX/MEM register and Data_Memory.
// Build option: define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses (cause 100).
module mem_access_ctrl #(
    parameter int ADDR_LIMIT = 4096,
    parameter int MAX_WAIT   = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_Func3,
    input  logic [31:0] req_Address,
    input  logic [31:0] req_Write_data,
    input  logic [4:0]  req_rd,
    output logic        Stall,
    output logic        Load_valid,
    output logic [31:0] Load_data,
    output logic [4:0]  Load_rd,
    output logic        Resp_fault,
    output logic [2:0]  Fault_cause,
    output logic        mem_Read,
    output logic        mem_Write,
    output logic [31:0] mem_Address,
    output logic [31:0] mem_Write_data,
    output logic [2:0]  mem_Func3,
    input  logic [31:0] mem_Read_data,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [31:0] LIMIT     = 32'(ADDR_LIMIT);
    localparam logic [7:0]  LAST_WAIT = 8'(MAX_WAIT - 1);

    localparam logic [2:0] CAUSE_NONE     = 3'b000;
    localparam logic [2:0] CAUSE_RANGE    = 3'b001;
    localparam logic [2:0] CAUSE_FUNC3    = 3'b010;
    localparam logic [2:0] CAUSE_TIMEOUT  = 3'b011;
    localparam logic [2:0] CAUSE_MISALIGN = 3'b100;

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic [4:0]  rd_q;
    logic [2:0]  req_cause;
    logic        accept;
    logic        finish_ok;
    logic        finish_timeout;

    // Request validation, highest priority first: func3, alignment, range.
    function automatic logic [2:0] check_request(input logic        write,
                                                 input logic [2:0]  f3,
                                                 input logic [31:0] addr);
        logic f3_ok;
        logic [2:0] cause;
        if (write) f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else       f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                           (f3 == 3'b100) || (f3 == 3'b101);
        cause = CAUSE_NONE;
        if (!f3_ok) begin
            cause = CAUSE_FUNC3;
`ifdef MISALIGN_TRAP_EN
        end else if ((f3[1:0] == 2'b01 && addr[0]) ||
                     (f3[1:0] == 2'b10 && addr[1:0] != 2'b00)) begin
            cause = CAUSE_MISALIGN;
`endif
        end else if (addr >= LIMIT) begin
            cause = CAUSE_RANGE;
        end
        return cause;
    endfunction

    assign req_cause = check_request(req_write, req_Func3, req_Address);
    assign Stall     = (state == IDLE && req_valid) || (state == BUSY);

    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        finish_ok      = 1'b0;
        finish_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = (req_cause == CAUSE_NONE) ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (!mem_busywait) begin
                    finish_ok  = 1'b1;
                    state_next = RESP;
                end else if (wait_cnt == LAST_WAIT) begin
                    finish_timeout = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            wait_cnt       <= 8'd0;
            rd_q           <= 5'd0;
            mem_Read       <= 1'b0;
            mem_Write      <= 1'b0;
            mem_Address    <= 32'd0;
            mem_Write_data <= 32'd0;
            mem_Func3      <= 3'd0;
            Load_valid     <= 1'b0;
            Load_data      <= 32'd0;
            Load_rd        <= 5'd0;
            Resp_fault     <= 1'b0;
            Fault_cause    <= CAUSE_NONE;
        end else begin
            state      <= state_next;
            Load_valid <= 1'b0;
            Resp_fault <= 1'b0;

            if (accept) begin
                if (req_cause == CAUSE_NONE) begin
                    mem_Address    <= req_Address;
                    mem_Write_data <= req_Write_data;
                    mem_Func3      <= req_Func3;
                    rd_q           <= req_rd;
                    mem_Read       <= !req_write;
                    mem_Write      <= req_write;
                    wait_cnt       <= 8'd0;
                end else begin
                    Resp_fault  <= 1'b1;
                    Fault_cause <= req_cause;
                end
            end

            if (state == BUSY) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            // Completion: the strobe direction tells a load from a store.
            if (finish_ok) begin
                mem_Read    <= 1'b0;
                mem_Write   <= 1'b0;
                Fault_cause <= CAUSE_NONE;
                if (mem_Read) begin
                    Load_valid <= 1'b1;
                    Load_data  <= mem_Read_data;
                    Load_rd    <= rd_q;
                end
            end

            if (finish_timeout) begin
                mem_Read    <= 1'b0;
                mem_Write   <= 1'b0;
                Resp_fault  <= 1'b1;
                Fault_cause <= CAUSE_TIMEOUT;
            end
        end
    end

endmodule
